// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ==========================================================================
// sync_fifo_pkg: shared defaults and parameter legality helpers. Rev 1.0
// ==========================================================================
package sync_fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 6;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic bit afull_th_ok(input int th, input int depth);
    return (th >= 1) && (th <= depth);
  endfunction

  function automatic bit aempty_th_ok(input int th, input int depth);
    return (th >= 0) && (th <= depth - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ==========================================================================
// sync_fifo_ram: DEPTH x DATA_W storage, sync write, async read. Rev 1.0
// ==========================================================================
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  // Storage is deliberately not reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ==========================================================================
// sync_fifo_param: parametrised single-clock FIFO, optional FWFT read. Rev 1.0
// ==========================================================================
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AFULL_TH  = fifo_depth(ADDR_W) - 8,
  parameter int AEMPTY_TH = 8,
  parameter int FWFT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  localparam logic [ADDR_W:0]   c_depth_cnt  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_afull_cnt  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0]   c_aempty_cnt = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0]   c_cnt_one    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("sync_fifo_param: DATA_W must be at least 1");
  end
  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("sync_fifo_param: ADDR_W must be at least 2");
  end
  if (!afull_th_ok(AFULL_TH, DEPTH)) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_TH outside 1..DEPTH");
  end
  if (!aempty_th_ok(AEMPTY_TH, DEPTH)) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_TH outside 0..DEPTH-1");
  end

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_wa;
  logic              w_ra;
  logic [DATA_W-1:0] w_mem_rd;

  assign w_full  = (r_count == c_depth_cnt);
  assign w_empty = (r_count == '0);
  assign w_wa    = wr_en & ~w_full;
  assign w_ra    = rd_en & ~w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wa) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_ra) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_wa, w_ra})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full)  r_overflow  <= 1'b1;
      if (rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  // A flush drops any concurrent write so the array is never touched by it.
  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wa & ~clr),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rd)
  );

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = w_mem_rd;
    assign rd_valid = ~w_empty;
  end else begin : g_std
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else if (clr) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else if (w_ra) begin
        r_rd_data  <= w_mem_rd;
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_afull_cnt);
  assign almost_empty = (r_count <= c_aempty_cnt);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ==========================================================================
// tb_sync_fifo_param: randomised + directed bench against a queue model. Rev 1.0
// ==========================================================================
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: standard read mode, 8 x 64.
  logic       rst0, clr0, wr0, rd0;
  logic [7:0] wd0, rdd0;
  logic       rv0, full0, empty0, af0, ae0, ovf0, udf0;
  logic [6:0] cnt0;

  // FWFT instance: 16 x 8.
  logic        rst1, clr1, wr1, rd1;
  logic [15:0] wd1, rdd1;
  logic        rv1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0]  cnt1;

  sync_fifo_param dut0 (
    .clk(clk), .rst(rst0), .clr(clr0), .wr_en(wr0), .wr_data(wd0), .rd_en(rd0),
    .rd_data(rdd0), .rd_valid(rv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_param #(
    .DATA_W(16), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)
  ) dut1 (
    .clk(clk), .rst(rst1), .clr(clr1), .wr_en(wr1), .wr_data(wd1), .rd_en(rd1),
    .rd_data(rdd1), .rd_valid(rv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(udf1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the sticky flags.
  logic [7:0]  q0[$];
  bit          m_ovf0, m_udf0, m_rv0;
  logic [7:0]  m_rd0;
  logic [15:0] q1[$];
  bit          m_ovf1, m_udf1;

  task automatic model0_reset();
    q0.delete(); m_ovf0 = 0; m_udf0 = 0; m_rv0 = 0; m_rd0 = '0;
  endtask

  task automatic model1_reset();
    q1.delete(); m_ovf1 = 0; m_udf1 = 0;
  endtask

  task automatic model0_edge(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit f, e;
    if (c) begin
      model0_reset();
      return;
    end
    f = (q0.size() == 64);
    e = (q0.size() == 0);
    if (w && f) m_ovf0 = 1;
    if (r && e) m_udf0 = 1;
    if (r && !e) begin
      m_rd0 = q0.pop_front();
      m_rv0 = 1;
    end else begin
      m_rv0 = 0;
    end
    if (w && !f) q0.push_back(d);
  endtask

  task automatic model1_edge(input bit w, input logic [15:0] d, input bit r, input bit c);
    bit f, e;
    if (c) begin
      model1_reset();
      return;
    end
    f = (q1.size() == 8);
    e = (q1.size() == 0);
    if (w && f) m_ovf1 = 1;
    if (r && e) m_udf1 = 1;
    if (r && !e) void'(q1.pop_front());
    if (w && !f) q1.push_back(d);
  endtask

  task automatic check0(input string ctx);
    check_eq({ctx, ".count"},  32'(cnt0),   32'(q0.size()));
    check_eq({ctx, ".full"},   32'(full0),  32'(q0.size() == 64));
    check_eq({ctx, ".empty"},  32'(empty0), 32'(q0.size() == 0));
    check_eq({ctx, ".afull"},  32'(af0),    32'(q0.size() >= 56));
    check_eq({ctx, ".aempty"}, 32'(ae0),    32'(q0.size() <= 8));
    check_eq({ctx, ".ovf"},    32'(ovf0),   32'(m_ovf0));
    check_eq({ctx, ".udf"},    32'(udf0),   32'(m_udf0));
    check_eq({ctx, ".rvalid"}, 32'(rv0),    32'(m_rv0));
    check_eq({ctx, ".rdata"},  32'(rdd0),   32'(m_rd0));
  endtask

  task automatic check1(input string ctx);
    check_eq({ctx, ".count"},  32'(cnt1),   32'(q1.size()));
    check_eq({ctx, ".full"},   32'(full1),  32'(q1.size() == 8));
    check_eq({ctx, ".empty"},  32'(empty1), 32'(q1.size() == 0));
    check_eq({ctx, ".afull"},  32'(af1),    32'(q1.size() >= 6));
    check_eq({ctx, ".aempty"}, 32'(ae1),    32'(q1.size() <= 1));
    check_eq({ctx, ".ovf"},    32'(ovf1),   32'(m_ovf1));
    check_eq({ctx, ".udf"},    32'(udf1),   32'(m_udf1));
    check_eq({ctx, ".rvalid"}, 32'(rv1),    32'(q1.size() != 0));
    if (q1.size() != 0) check_eq({ctx, ".head"}, 32'(rdd1), 32'(q1[0]));
  endtask

  task automatic step0(input bit w, input logic [7:0] d, input bit r, input bit c, input string ctx);
    @(negedge clk);
    wr0 = w; wd0 = d; rd0 = r; clr0 = c;
    @(posedge clk);
    model0_edge(w, d, r, c);
    #1;
    check0(ctx);
  endtask

  task automatic step1(input bit w, input logic [15:0] d, input bit r, input bit c, input string ctx);
    @(negedge clk);
    wr1 = w; wd1 = d; rd1 = r; clr1 = c;
    @(posedge clk);
    model1_edge(w, d, r, c);
    #1;
    check1(ctx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int af_rise;
    rst0 = 1; clr0 = 0; wr0 = 0; rd0 = 0; wd0 = '0;
    rst1 = 1; clr1 = 0; wr1 = 0; rd1 = 0; wd1 = '0;
    model0_reset();
    model1_reset();
    #1;
    check0("reset");
    check_eq("reset.ae1", 32'(ae1), 32'd1);
    @(negedge clk);
    rst0 = 0; rst1 = 0;

    // Fill with 0x00..0x3F; almost_full must first rise at 56.
    af_rise = -1;
    for (int i = 0; i < 64; i++) begin
      step0(1, 8'(i), 0, 0, "fill");
      if (af0 && af_rise < 0) af_rise = int'(cnt0);
    end
    check_eq("afull_rise", 32'(af_rise), 32'd56);
    check_eq("fill_full",  32'(full0), 32'd1);
    check_eq("fill_count", 32'(cnt0), 32'd64);
    step0(1, 8'hAA, 0, 0, "ovf");
    check_eq("ovf_set",   32'(ovf0), 32'd1);
    check_eq("ovf_count", 32'(cnt0), 32'd64);

    for (int i = 0; i < 64; i++) begin
      step0(0, 8'h00, 1, 0, "drain");
      check_eq("drain_data", 32'(rdd0), 32'(i));
    end
    check_eq("drain_empty", 32'(empty0), 32'd1);
    step0(0, 8'h00, 1, 0, "udf");
    check_eq("udf_set",    32'(udf0), 32'd1);
    check_eq("udf_rvalid", 32'(rv0), 32'd0);

    // Simultaneous wr+rd at the full and empty boundaries.
    step0(0, 8'h00, 0, 1, "clr");
    for (int i = 0; i < 64; i++) step0(1, 8'(i + 64), 0, 0, "fill2");
    step0(1, 8'h55, 1, 0, "bnd_full");
    check_eq("bnd_full_count", 32'(cnt0), 32'd63);
    check_eq("bnd_full_ovf",   32'(ovf0), 32'd1);
    step0(0, 8'h00, 0, 1, "clr");
    step0(1, 8'h77, 1, 0, "bnd_empty");
    check_eq("bnd_empty_count", 32'(cnt0), 32'd1);
    check_eq("bnd_empty_udf",   32'(udf0), 32'd1);
    step0(0, 8'h00, 1, 0, "bnd_read");
    check_eq("bnd_read_data", 32'(rdd0), 32'h77);

    // Wrap-around: steady count of 10 with concurrent traffic.
    step0(0, 8'h00, 0, 1, "clr");
    for (int i = 0; i < 10; i++) step0(1, 8'(i), 0, 0, "prewrap");
    for (int i = 0; i < 100; i++) begin
      step0(1, 8'(i + 10), 1, 0, "wrap");
      check_eq("wrap_count", 32'(cnt0), 32'd10);
      check_eq("wrap_data",  32'(rdd0), 32'(i));
    end

    // Random traffic: write-heavy then read-heavy phases, rare flushes.
    step0(0, 8'h00, 0, 1, "clr");
    for (int i = 0; i < 400; i++) begin
      bit w, r, c;
      if (i < 200) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 99) == 0);
      step0(w, 8'($urandom), r, c, "rand");
    end

    // Flush at count 20 with overflow set, concurrent with a write.
    step0(0, 8'h00, 0, 1, "clr");
    for (int i = 0; i < 64; i++) step0(1, 8'(i), 0, 0, "fill3");
    step0(1, 8'hAB, 0, 0, "ovf3");
    for (int i = 0; i < 44; i++) step0(0, 8'h00, 1, 0, "to20");
    check_eq("pre_flush_count", 32'(cnt0), 32'd20);
    check_eq("pre_flush_ovf",   32'(ovf0), 32'd1);
    step0(1, 8'hEE, 0, 1, "flush");
    check_eq("flush_count", 32'(cnt0), 32'd0);
    check_eq("flush_empty", 32'(empty0), 32'd1);
    check_eq("flush_ovf",   32'(ovf0), 32'd0);
    step0(0, 8'h00, 0, 0, "flush_idle");
    check_eq("flush_dropped", 32'(cnt0), 32'd0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 5; i++) step0(1, 8'(i + 8'h90), (i > 2), 0, "burst");
    @(negedge clk);
    wr0 = 1; wd0 = 8'hC3; rd0 = 1;
    #2 rst0 = 1;
    #1;
    model0_reset();
    check0("arst");
    @(negedge clk);
    rst0 = 0; wr0 = 0; rd0 = 0;
    step0(1, 8'h3C, 0, 0, "post_rst_wr");
    step0(0, 8'h00, 1, 0, "post_rst_rd");
    check_eq("post_rst_data", 32'(rdd0), 32'h3C);

    // FWFT instance.
    check1("fwft_reset");
    step1(1, 16'hBEEF, 0, 0, "fwft_wr");
    check_eq("fwft_valid", 32'(rv1), 32'd1);
    check_eq("fwft_data",  32'(rdd1), 32'hBEEF);
    step1(0, 16'h0000, 1, 0, "fwft_pop");
    check_eq("fwft_empty", 32'(empty1), 32'd1);
    step1(1, 16'h1111, 0, 0, "fwft_wr2");
    step1(1, 16'h2222, 1, 0, "fwft_wr_rd");
    check_eq("fwft_next", 32'(rdd1), 32'h2222);
    for (int i = 0; i < 300; i++) begin
      bit w, r, c;
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 63) == 0);
      step1(w, 16'($urandom), r, c, "fwft_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
